// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package multicycle_pkg;

  // Controller states; the numeric encodings are visible on the State debug port.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (Instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // ALUControl encodings
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // True when the opcode is implemented; addi and j only exist with the extended set.
  function automatic logic is_legal_op(input logic [5:0] op, input logic ext_ops);
    logic legal;
    legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    if (ext_ops) legal = legal || (op == OP_ADDI) || (op == OP_J);
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's operation class and the R-type Function field to ALUControl.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o
);

  // Unknown function codes and the unused ALUOp code fall back to add.
  always_comb begin
    alu_ctrl_o = ALUC_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_ctrl_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALUC_ADD;
          FN_SUB:  alu_ctrl_o = ALUC_SUB;
          FN_AND:  alu_ctrl_o = ALUC_AND;
          FN_OR:   alu_ctrl_o = ALUC_OR;
          FN_SLT:  alu_ctrl_o = ALUC_SLT;
          default: alu_ctrl_o = ALUC_ADD;
        endcase
      end
      default: alu_ctrl_o = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath with memory-ready stretching
// and illegal-opcode detection.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit EXT_OPS       = 1'b1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [5:0] OpCode,
  input  logic [5:0] Function,
  input  logic       MemReady,
  output logic       MemToReg,
  output logic       RegDes,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PcWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic [1:0] PcSrc,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       Illegal,
  output logic [3:0] State
);

  state_e     state_q, state_d;
  logic       mem_rdy;
  aluop_e     alu_op;
  logic       alu_en;
  logic [2:0] alu_ctrl;

  assign mem_rdy = USE_MEM_READY ? MemReady : 1'b1;
  assign State   = state_q;

  alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct_i    (Function),
    .alu_ctrl_o (alu_ctrl)
  );

  // ALUControl is only driven in states that use the ALU; elsewhere it reads 0.
  assign ALUControl = alu_en ? alu_ctrl : '0;

  // State register with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic: memory states stall on mem_rdy, DECODE dispatches on OpCode.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OpCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = EXT_OPS ? S_ADDIEXEC : S_FETCH;
          OP_J:         state_d = EXT_OPS ? S_JUMP : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (OpCode == OP_LW)      state_d = S_MEMREAD;
        else if (OpCode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore strobes per state; everything is held at 0 while RSTn is low, so the
  // FETCH strobes cannot glitch high during reset even with MemReady asserted.
  always_comb begin
    MemToReg = 1'b0;
    RegDes   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PcWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    PcSrc    = '0;
    ALUSrcB  = '0;
    Illegal  = 1'b0;
    alu_op   = ALUOP_ADD;
    alu_en   = 1'b0;
    if (RSTn) begin
      case (state_q)
        S_FETCH: begin
          ALUSrcB = 2'b01;
          alu_en  = 1'b1;
          IRWrite = mem_rdy;
          PcWrite = mem_rdy;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          alu_en  = 1'b1;
          Illegal = !is_legal_op(OpCode, EXT_OPS);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          alu_en  = 1'b1;
        end
        S_MEMREAD: IorD = 1'b1;
        S_MEMWB: begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_FUNCT;
          alu_en  = 1'b1;
        end
        S_ALUWB: begin
          RegDes   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          alu_op  = ALUOP_SUB;
          alu_en  = 1'b1;
          PcSrc   = 2'b01;
          Branch  = 1'b1;
        end
        S_ADDIEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          alu_en  = 1'b1;
        end
        S_ADDIWB: RegWrite = 1'b1;
        S_JUMP: begin
          PcSrc   = 2'b10;
          PcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
